// File: rtl/e203_nice_udp_payload_loader_if.sv
// Bus bundle for the NICE UDP payload loader: NICE command/response, NICE ICB
// memory port and the payload stream towards the UDP TX path.
interface e203_nice_udp_payload_loader_if;
    logic        nice_req_valid;
    logic        nice_req_ready;
    logic [31:0] nice_req_inst;
    logic [31:0] nice_req_rs1;
    logic [31:0] nice_req_rs2;

    logic        nice_rsp_valid;
    logic        nice_rsp_ready;
    logic [31:0] nice_rsp_rdat;
    logic        nice_rsp_err;
    logic        nice_active;
    logic        nice_mem_holdup;

    logic        nice_icb_cmd_valid;
    logic        nice_icb_cmd_ready;
    logic [31:0] nice_icb_cmd_addr;
    logic        nice_icb_cmd_read;
    logic [31:0] nice_icb_cmd_wdata;
    logic [1:0]  nice_icb_cmd_size;

    logic        nice_icb_rsp_valid;
    logic [31:0] nice_icb_rsp_rdata;
    logic        nice_icb_rsp_err;
    logic        nice_icb_rsp_ready;

    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        pl_last;
    logic [2:0]  pl_nbytes;

    // Loader side
    modport slave (
        input  nice_req_valid, nice_req_inst, nice_req_rs1, nice_req_rs2,
        output nice_req_ready,
        output nice_rsp_valid, nice_rsp_rdat, nice_rsp_err, nice_active, nice_mem_holdup,
        input  nice_rsp_ready,
        output nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
        output nice_icb_cmd_wdata, nice_icb_cmd_size,
        input  nice_icb_cmd_ready,
        input  nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err,
        output nice_icb_rsp_ready,
        output pl_valid, pl_data, pl_last, pl_nbytes,
        input  pl_ready
    );

    // Core / memory / UDP TX side
    modport master (
        output nice_req_valid, nice_req_inst, nice_req_rs1, nice_req_rs2,
        input  nice_req_ready,
        input  nice_rsp_valid, nice_rsp_rdat, nice_rsp_err, nice_active, nice_mem_holdup,
        output nice_rsp_ready,
        input  nice_icb_cmd_valid, nice_icb_cmd_addr, nice_icb_cmd_read,
        input  nice_icb_cmd_wdata, nice_icb_cmd_size,
        output nice_icb_cmd_ready,
        output nice_icb_rsp_valid, nice_icb_rsp_rdata, nice_icb_rsp_err,
        input  nice_icb_rsp_ready,
        input  pl_valid, pl_data, pl_last, pl_nbytes,
        output pl_ready
    );
endinterface

// File: rtl/e203_nice_udp_payload_loader.sv
// NICE custom3 "udp_send": reads a payload over the NICE ICB port one word at a
// time and streams it through a small FWFT FIFO to the UDP TX path.
module e203_nice_udp_payload_loader #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int MAX_BYTES  = 1472,
    parameter int LEN_W      = 11
) (
    input  logic                                 nice_clk,
    input  logic                                 nice_rst_n,
    e203_nice_udp_payload_loader_if.slave        nice
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RSP} state_t;

    localparam logic [FIFO_AW:0]  DEPTH_V = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_BYTES);

    state_t state_reg, state_next;

    logic [31:0]      addr_reg;
    logic [LEN_W-1:0] len_reg, words_reg, rd_cnt_reg;
    logic             err_reg, outstanding_reg;

    // FIFO entry: {last, nbytes[2:0], data[31:0]}
    logic [35:0]        fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]   fifo_cnt_reg;

    logic             is_udp_send, issue_ok, cmd_hs, rsp_hs;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, last_word;
    logic [LEN_W-1:0] len_clamped, words_calc, rd_cnt_inc;
    logic [2:0]       last_nbytes;
    logic [35:0]      push_entry, head_entry;
    logic             unused_inst_bits;

    assign is_udp_send = (nice.nice_req_inst[6:0] == 7'h7b)
                       && (nice.nice_req_inst[14:12] == 3'b010)
                       && (nice.nice_req_inst[31:25] == 7'b0000010);
    assign unused_inst_bits = ^{nice.nice_req_inst[24:15], nice.nice_req_inst[11:7]};

    assign len_clamped = (nice.nice_req_rs2 > 32'(MAX_BYTES)) ? MAX_LEN
                                                              : nice.nice_req_rs2[LEN_W-1:0];
    assign words_calc  = (len_clamped + LEN_W'(3)) >> 2;

    // Issue only when a returning word is guaranteed a FIFO slot.
    assign issue_ok  = (fifo_cnt_reg + {{FIFO_AW{1'b0}}, outstanding_reg}) < DEPTH_V;
    assign cmd_hs    = (state_reg == ISSUE) && issue_ok && nice.nice_icb_cmd_ready;
    assign rsp_hs    = (state_reg == RSP) && nice.nice_rsp_ready;

    assign rd_cnt_inc  = rd_cnt_reg + LEN_W'(1);
    assign last_word   = (rd_cnt_inc == words_reg);
    assign last_nbytes = (len_reg[1:0] == 2'b00) ? 3'd4 : {1'b0, len_reg[1:0]};
    assign push_entry  = {last_word, (last_word ? last_nbytes : 3'd4), nice.nice_icb_rsp_rdata};

    assign fifo_push  = (state_reg == WAIT) && nice.nice_icb_rsp_valid && !nice.nice_icb_rsp_err;
    assign fifo_empty = (fifo_cnt_reg == '0);
    assign fifo_full  = (fifo_cnt_reg == DEPTH_V);
    assign fifo_pop   = !fifo_empty && nice.pl_ready;
    assign fifo_flush = rsp_hs;
    assign head_entry = fifo_mem[rd_ptr_reg];

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) state_reg <= IDLE;
        else             state_reg <= state_next;
    end

    always_comb begin
        state_next              = state_reg;
        nice.nice_req_ready     = 1'b0;
        nice.nice_rsp_valid     = 1'b0;
        nice.nice_active        = 1'b1;
        nice.nice_mem_holdup    = 1'b0;
        nice.nice_icb_cmd_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                nice.nice_req_ready = 1'b1;
                nice.nice_active    = 1'b0;
                if (nice.nice_req_valid) begin
                    if (!is_udp_send || (nice.nice_req_rs2 == 32'd0)) state_next = RSP;
                    else                                              state_next = ISSUE;
                end
            end
            ISSUE: begin
                nice.nice_mem_holdup    = 1'b1;
                nice.nice_icb_cmd_valid = issue_ok;
                if (cmd_hs) state_next = WAIT;
            end
            WAIT: begin
                nice.nice_mem_holdup = 1'b1;
                if (nice.nice_icb_rsp_valid) begin
                    if (nice.nice_icb_rsp_err) state_next = RSP;
                    else if (last_word)        state_next = DRAIN;
                    else                       state_next = ISSUE;
                end
            end
            DRAIN: begin
                if (fifo_empty) state_next = RSP;
            end
            RSP: begin
                nice.nice_rsp_valid = 1'b1;
                if (nice.nice_rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            addr_reg        <= '0;
            len_reg         <= '0;
            words_reg       <= '0;
            rd_cnt_reg      <= '0;
            err_reg         <= 1'b0;
            outstanding_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (nice.nice_req_valid) begin
                        err_reg    <= !is_udp_send;
                        rd_cnt_reg <= '0;
                        if (is_udp_send) begin
                            addr_reg  <= nice.nice_req_rs1 & ~32'h3;
                            len_reg   <= len_clamped;
                            words_reg <= words_calc;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_hs) outstanding_reg <= 1'b1;
                end
                WAIT: begin
                    if (nice.nice_icb_rsp_valid) begin
                        outstanding_reg <= 1'b0;
                        if (nice.nice_icb_rsp_err) begin
                            err_reg <= 1'b1;
                        end else begin
                            rd_cnt_reg <= rd_cnt_inc;
                            addr_reg   <= addr_reg + 32'd4;
                        end
                    end
                end
                RSP: begin
                    if (nice.nice_rsp_ready) begin
                        err_reg    <= 1'b0;
                        rd_cnt_reg <= '0;
                        len_reg    <= '0;
                        words_reg  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload FIFO control; a flush on response handshake discards leftovers of an aborted transfer.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else if (fifo_flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fifo_cnt_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + FIFO_AW'(1);
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + FIFO_AW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + (FIFO_AW + 1)'(1);
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - (FIFO_AW + 1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge nice_clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg] <= push_entry;
    end

    assert property (@(posedge nice_clk) disable iff (!nice_rst_n) !(fifo_push && fifo_full));

    assign nice.nice_rsp_rdat      = 32'(rd_cnt_reg);
    assign nice.nice_rsp_err       = err_reg;
    assign nice.nice_icb_cmd_addr  = addr_reg;
    assign nice.nice_icb_cmd_read  = 1'b1;
    assign nice.nice_icb_cmd_wdata = 32'd0;
    assign nice.nice_icb_cmd_size  = 2'b10;
    assign nice.nice_icb_rsp_ready = 1'b1;

    assign nice.pl_valid  = !fifo_empty;
    assign nice.pl_data   = head_entry[31:0];
    assign nice.pl_nbytes = head_entry[34:32];
    assign nice.pl_last   = head_entry[35];
endmodule

// File: tb/tb_e203_nice_udp_payload_loader.sv
// Directed bench for the NICE UDP payload loader: ICB memory model, payload sink
// and NICE command sequences with hand-derived expected responses.
module tb_e203_nice_udp_payload_loader;
    localparam logic [31:0] INST_UDP = 32'h0400_207B;  // custom3, func3=010, func7=0000010
    localparam logic [31:0] INST_BAD = 32'h0200_207B;  // custom3, func7=0000001
    localparam logic [31:0] MEM_TAG  = 32'h1111_0000;  // memory word = address + MEM_TAG

    logic nice_clk   = 1'b0;
    logic nice_rst_n = 1'b0;
    always #5 nice_clk = ~nice_clk;

    e203_nice_udp_payload_loader_if nif();

    e203_nice_udp_payload_loader dut (
        .nice_clk   (nice_clk),
        .nice_rst_n (nice_rst_n),
        .nice       (nif)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_base = '0;
    int          exp_words = 0;
    int          exp_len   = 0;
    int          err_at    = -1;
    int          icb_cnt   = 0;
    int          pl_cnt    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge nice_clk);
    endtask

    task automatic start_test(input logic [31:0] base, input int len, input int words);
        exp_base  = base;
        exp_len   = len;
        exp_words = words;
        icb_cnt   = 0;
        pl_cnt    = 0;
        $display("-- test base=0x%08h len=%0d words=%0d", base, len, words);
    endtask

    task automatic send_cmd(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2);
        int n = 0;
        nif.nice_req_valid = 1'b1;
        nif.nice_req_inst  = inst;
        nif.nice_req_rs1   = rs1;
        nif.nice_req_rs2   = rs2;
        while (!nif.nice_req_ready && n < 200) begin
            @(negedge nice_clk);
            n++;
        end
        check("req_accepted", 64'(n < 200), 64'd1);
        @(negedge nice_clk);
        nif.nice_req_valid = 1'b0;
        $display("cmd inst=0x%08h rs1=0x%08h rs2=%0d", inst, rs1, rs2);
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdat, input logic exp_err,
                            input int hold, output int waited);
        int n = 0;
        while (!nif.nice_rsp_valid && n < 5000) begin
            @(negedge nice_clk);
            n++;
        end
        waited = n;
        check({tag, "_rsp_seen"}, 64'(nif.nice_rsp_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge nice_clk);
            check({tag, "_rsp_hold"}, {nif.nice_rsp_valid, nif.nice_rsp_rdat, nif.nice_rsp_err},
                  {1'b1, exp_rdat, exp_err});
        end
        check({tag, "_rdat"}, 64'(nif.nice_rsp_rdat), 64'(exp_rdat));
        check({tag, "_err"}, 64'(nif.nice_rsp_err), 64'(exp_err));
        $display("rsp %s rdat=%0d err=%0d after %0d cycles", tag, nif.nice_rsp_rdat, nif.nice_rsp_err, n);
        nif.nice_rsp_ready = 1'b1;
        @(negedge nice_clk);
        nif.nice_rsp_ready = 1'b0;
        check({tag, "_back_idle"}, {nif.nice_rsp_valid, nif.nice_active, nif.nice_req_ready}, 3'b001);
    endtask

    // ICB memory: single-cycle response one cycle after each command handshake.
    initial begin
        logic        pend;
        logic [31:0] pend_addr;
        int          pend_idx;
        pend      = 1'b0;
        pend_addr = '0;
        pend_idx  = 0;
        nif.nice_icb_cmd_ready = 1'b1;
        nif.nice_icb_rsp_valid = 1'b0;
        nif.nice_icb_rsp_rdata = '0;
        nif.nice_icb_rsp_err   = 1'b0;
        forever begin
            @(negedge nice_clk);
            #1;
            nif.nice_icb_rsp_valid = 1'b0;
            nif.nice_icb_rsp_err   = 1'b0;
            if (!nice_rst_n) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    nif.nice_icb_rsp_valid = 1'b1;
                    nif.nice_icb_rsp_rdata = pend_addr + MEM_TAG;
                    nif.nice_icb_rsp_err   = (pend_idx == err_at);
                    pend = 1'b0;
                end
                if (nif.nice_icb_cmd_valid) begin
                    check("icb_addr", 64'(nif.nice_icb_cmd_addr), 64'(exp_base + 32'(4 * icb_cnt)));
                    check("icb_attr", {nif.nice_icb_cmd_read, nif.nice_icb_cmd_size, nif.nice_icb_cmd_wdata},
                          {1'b1, 2'b10, 32'h0});
                    pend      = 1'b1;
                    pend_addr = nif.nice_icb_cmd_addr;
                    pend_idx  = icb_cnt;
                    icb_cnt++;
                end
            end
        end
    end

    // Payload sink: checks each accepted word against the expected packet layout.
    initial begin
        logic       exp_last;
        logic [2:0] exp_nb;
        forever begin
            @(negedge nice_clk);
            #1;
            if (nice_rst_n && nif.pl_valid && nif.pl_ready) begin
                exp_last = (pl_cnt == exp_words - 1);
                exp_nb   = !exp_last ? 3'd4 : ((exp_len % 4 == 0) ? 3'd4 : 3'(exp_len % 4));
                check("pl_data", 64'(nif.pl_data), 64'(exp_base + 32'(4 * pl_cnt) + MEM_TAG));
                check("pl_tag", {nif.pl_last, nif.pl_nbytes}, {exp_last, exp_nb});
                pl_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        nif.nice_req_valid = 1'b0;
        nif.nice_req_inst  = '0;
        nif.nice_req_rs1   = '0;
        nif.nice_req_rs2   = '0;
        nif.nice_rsp_ready = 1'b0;
        nif.pl_ready       = 1'b0;

        tick(3);
        nice_rst_n = 1'b1;
        tick(1);
        check("reset_state",
              {nif.nice_req_ready, nif.nice_rsp_valid, nif.nice_active, nif.nice_mem_holdup,
               nif.nice_icb_cmd_valid, nif.pl_valid, nif.nice_rsp_err, nif.nice_rsp_rdat},
              {7'b1000000, 32'h0});

        // 10 bytes: 3 words, last word carries 2 bytes
        start_test(32'h8000_0000, 10, 3);
        nif.pl_ready = 1'b1;
        send_cmd(INST_UDP, 32'h8000_0000, 32'd10);
        wait_rsp("len10", 32'd3, 1'b0, 0, w);
        check("len10_icb_cnt", 64'(icb_cnt), 64'd3);
        check("len10_pl_cnt", 64'(pl_cnt), 64'd3);

        // 64 bytes with a stalled sink: reads stop once the FIFO is committed full
        start_test(32'h0000_1000, 64, 16);
        nif.pl_ready = 1'b0;
        send_cmd(INST_UDP, 32'h0000_1000, 32'd64);
        tick(40);
        check("stall_icb_cnt", 64'(icb_cnt), 64'd8);
        check("stall_pl_cnt", 64'(pl_cnt), 64'd0);
        check("stall_flags", {nif.pl_valid, nif.nice_mem_holdup, nif.nice_icb_cmd_valid}, 3'b110);
        nif.pl_ready = 1'b1;
        wait_rsp("len64", 32'd16, 1'b0, 0, w);
        check("len64_icb_cnt", 64'(icb_cnt), 64'd16);
        check("len64_pl_cnt", 64'(pl_cnt), 64'd16);

        // ICB error on the second read aborts; the first word still streams out
        start_test(32'h0000_3000, 16, 4);
        err_at = 1;
        send_cmd(INST_UDP, 32'h0000_3000, 32'd16);
        wait_rsp("icb_err", 32'd1, 1'b1, 0, w);
        tick(5);
        check("icb_err_icb_cnt", 64'(icb_cnt), 64'd2);
        check("icb_err_pl_cnt", 64'(pl_cnt), 64'd1);
        err_at = -1;
        start_test(32'h0000_3100, 4, 1);
        send_cmd(INST_UDP, 32'h0000_3103, 32'd4);  // unaligned rs1 low bits ignored
        wait_rsp("after_err", 32'd1, 1'b0, 0, w);
        check("after_err_pl_cnt", 64'(pl_cnt), 64'd1);

        // Unsupported func7 and zero length: immediate response, no memory traffic
        start_test(32'h0000_4000, 0, 0);
        send_cmd(INST_BAD, 32'h0000_4000, 32'd8);
        wait_rsp("bad_func", 32'd0, 1'b1, 0, w);
        check("bad_func_latency", 64'(w), 64'd0);
        send_cmd(INST_UDP, 32'h0000_4000, 32'd0);
        wait_rsp("zero_len", 32'd0, 1'b0, 0, w);
        check("zero_len_latency", 64'(w), 64'd0);
        check("no_icb_traffic", 64'(icb_cnt), 64'd0);

        // Oversized request is clamped; response held while rsp_ready is low
        start_test(32'h2000_0000, 1472, 368);
        send_cmd(INST_UDP, 32'h2000_0000, 32'd5000);
        wait_rsp("clamp", 32'd368, 1'b0, 5, w);
        check("clamp_icb_cnt", 64'(icb_cnt), 64'd368);
        check("clamp_pl_cnt", 64'(pl_cnt), 64'd368);

        // Reset asserted while a read is outstanding
        start_test(32'h0000_5000, 64, 16);
        nif.pl_ready = 1'b0;
        send_cmd(INST_UDP, 32'h0000_5000, 32'd64);
        tick(2);
        w = 0;
        while (!(nif.nice_mem_holdup && !nif.nice_icb_cmd_valid) && w < 50) begin
            tick(1);
            w++;
        end
        check("reached_wait", 64'(w < 50), 64'd1);
        nice_rst_n = 1'b0;
        #1;
        check("mid_reset_outputs",
              {nif.nice_req_ready, nif.nice_rsp_valid, nif.nice_active, nif.nice_mem_holdup,
               nif.nice_icb_cmd_valid, nif.pl_valid, nif.nice_rsp_err, nif.nice_rsp_rdat},
              {7'b1000000, 32'h0});
        tick(2);
        nice_rst_n = 1'b1;
        tick(1);
        check("post_reset_outputs",
              {nif.nice_req_ready, nif.nice_rsp_valid, nif.nice_active, nif.pl_valid},
              4'b1000);
        start_test(32'h0000_6000, 8, 2);
        nif.pl_ready = 1'b1;
        send_cmd(INST_UDP, 32'h0000_6000, 32'd8);
        wait_rsp("post_reset", 32'd2, 1'b0, 0, w);
        check("post_reset_pl_cnt", 64'(pl_cnt), 64'd2);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
